instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer.sv | 159 +++++++++++++++
 tb/tb_instruction_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer
// Description : Loads a program of up to 32 26-bit words into an external
//               store, then fetches and issues it over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_sequencer (
  input  logic        clk,
  input  logic        ic_rst_n,
  input  logic        ic_load_start,
  input  logic        ic_ld_valid,
  input  logic [25:0] ic_ld_data,
  input  logic        ic_ld_last,
  output logic        ic_ld_ready,
  input  logic        ic_run,
  output logic        ic_mem_we,
  output logic [4:0]  ic_mem_addr,
  output logic [25:0] ic_mem_wdata,
  input  logic [25:0] ic_mem_rdata,
  output logic [25:0] ic_iw,
  output logic        ic_iw_valid,
  input  logic        ic_iw_ready,
  output logic        ic_busy,
  output logic        ic_done,
  output logic [5:0]  ic_prog_len
);

  localparam int unsigned c_IW_W   = 26;
  localparam int unsigned c_AW     = 5;
  localparam logic [c_AW-1:0] c_ADDR_MAX = 5'd31;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_LOAD  = 3'd1;
  localparam logic [2:0] c_ST_FETCH = 3'd2;
  localparam logic [2:0] c_ST_ISSUE = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [c_AW-1:0]   r_pc;
  logic [c_AW-1:0]   r_ld_cnt;
  logic [c_AW:0]     r_prog_len;
  logic [c_IW_W-1:0] r_iw;

  logic              w_ld_fire;
  logic              w_ld_final;
  logic              w_last_pc;
  logic [c_AW-1:0]   w_pc_prefetch;

  assign w_ld_fire     = (r_state == c_ST_LOAD) && ic_ld_valid;
  assign w_ld_final    = ic_ld_last || (r_ld_cnt == c_ADDR_MAX);
  assign w_last_pc     = ({1'b0, r_pc} == (r_prog_len - 6'd1));
  assign w_pc_prefetch = (r_pc == c_ADDR_MAX) ? r_pc : (r_pc + 5'd1);

  // State register
  always_ff @(posedge clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (ic_load_start) begin
          w_state_nxt = c_ST_LOAD;
        end else if (ic_run) begin
          w_state_nxt = (r_prog_len != 6'd0) ? c_ST_FETCH : c_ST_DONE;
        end
      end
      c_ST_LOAD: begin
        if (w_ld_fire && w_ld_final) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      c_ST_FETCH: w_state_nxt = c_ST_ISSUE;
      c_ST_ISSUE: begin
        if (ic_iw_ready) begin
          w_state_nxt = w_last_pc ? c_ST_DONE : c_ST_FETCH;
        end
      end
      c_ST_DONE: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Counters, program length and issued word
  always_ff @(posedge clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      r_pc       <= '0;
      r_ld_cnt   <= '0;
      r_prog_len <= '0;
      r_iw       <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (ic_load_start) begin
            r_ld_cnt <= '0;
          end else if (ic_run) begin
            r_pc <= '0;
          end
        end
        c_ST_LOAD: begin
          if (w_ld_fire) begin
            if (w_ld_final) begin
              r_prog_len <= {1'b0, r_ld_cnt} + 6'd1;
            end else begin
              r_ld_cnt <= r_ld_cnt + 5'd1;
            end
          end
        end
        c_ST_FETCH: r_iw <= ic_mem_rdata;
        c_ST_ISSUE: begin
          if (ic_iw_ready && !w_last_pc) begin
            r_pc <= r_pc + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode. The store has one cycle of read latency, so ISSUE already
  // presents the following pc; FETCH re-presents it while the word is captured.
  always_comb begin
    ic_ld_ready  = 1'b0;
    ic_mem_we    = 1'b0;
    ic_mem_addr  = '0;
    ic_mem_wdata = '0;
    ic_iw_valid  = 1'b0;
    ic_done      = 1'b0;
    case (r_state)
      c_ST_LOAD: begin
        ic_ld_ready  = 1'b1;
        ic_mem_we    = ic_ld_valid;
        ic_mem_addr  = r_ld_cnt;
        ic_mem_wdata = ic_ld_data;
      end
      c_ST_FETCH: ic_mem_addr = r_pc;
      c_ST_ISSUE: begin
        ic_iw_valid = 1'b1;
        ic_mem_addr = w_pc_prefetch;
      end
      c_ST_DONE: ic_done = 1'b1;
      default: ;
    endcase
  end

  assign ic_busy     = (r_state != c_ST_IDLE);
  assign ic_iw       = r_iw;
  assign ic_prog_len = r_prog_len;

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_sequencer
// Description : Randomised self-checking bench with a behavioural program model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        ic_rst_n;
  logic        ic_load_start;
  logic        ic_ld_valid;
  logic [25:0] ic_ld_data;
  logic        ic_ld_last;
  logic        ic_ld_ready;
  logic        ic_run;
  logic        ic_mem_we;
  logic [4:0]  ic_mem_addr;
  logic [25:0] ic_mem_wdata;
  logic [25:0] ic_mem_rdata;
  logic [25:0] ic_iw;
  logic        ic_iw_valid;
  logic        ic_iw_ready;
  logic        ic_busy;
  logic        ic_done;
  logic [5:0]  ic_prog_len;

  instruction_sequencer dut (
    .clk          (clk),
    .ic_rst_n     (ic_rst_n),
    .ic_load_start(ic_load_start),
    .ic_ld_valid  (ic_ld_valid),
    .ic_ld_data   (ic_ld_data),
    .ic_ld_last   (ic_ld_last),
    .ic_ld_ready  (ic_ld_ready),
    .ic_run       (ic_run),
    .ic_mem_we    (ic_mem_we),
    .ic_mem_addr  (ic_mem_addr),
    .ic_mem_wdata (ic_mem_wdata),
    .ic_mem_rdata (ic_mem_rdata),
    .ic_iw        (ic_iw),
    .ic_iw_valid  (ic_iw_valid),
    .ic_iw_ready  (ic_iw_ready),
    .ic_busy      (ic_busy),
    .ic_done      (ic_done),
    .ic_prog_len  (ic_prog_len)
  );

  always #5 clk = ~clk;

  // 32x26 store with one cycle of read latency
  logic [25:0] mem [0:31];
  always @(posedge clk) begin
    if (ic_mem_we) mem[ic_mem_addr] <= ic_mem_wdata;
    ic_mem_rdata <= mem[ic_mem_addr];
  end

  logic [30:0] wlog[$];
  always @(posedge clk) begin
    if (ic_mem_we) wlog.push_back({ic_mem_addr, ic_mem_wdata});
  end

  logic [25:0] words [0:39];
  logic [25:0] prog  [0:31];
  int          model_len;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_reset_state();
    check_eq("rst_busy",     {31'd0, ic_busy},     32'd0);
    check_eq("rst_done",     {31'd0, ic_done},     32'd0);
    check_eq("rst_ld_ready", {31'd0, ic_ld_ready}, 32'd0);
    check_eq("rst_mem_we",   {31'd0, ic_mem_we},   32'd0);
    check_eq("rst_iw_valid", {31'd0, ic_iw_valid}, 32'd0);
    check_eq("rst_iw",       {6'd0, ic_iw},        32'd0);
    check_eq("rst_prog_len", {26'd0, ic_prog_len}, 32'd0);
    check_eq("rst_mem_addr", {27'd0, ic_mem_addr}, 32'd0);
  endtask

  // Offers n_offer words with random gaps; last_idx < 0 means no last flag.
  task automatic load_prog(input int n_offer, input int last_idx, input bit combo_run);
    int exp_n;
    int idx;
    bit finished;
    bit v;
    exp_n = (last_idx >= 0 && last_idx < 32) ? last_idx + 1 : 32;
    wlog.delete();
    @(negedge clk);
    ic_load_start = 1'b1;
    ic_run        = combo_run;
    @(negedge clk);
    ic_load_start = 1'b0;
    ic_run        = 1'b0;
    idx = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!ic_ld_ready) begin
        finished = 1'b1;
        break;
      end
      v = (idx < n_offer) && ($urandom_range(3) != 0);
      ic_ld_valid = v;
      ic_ld_data  = words[idx];
      ic_ld_last  = (idx == last_idx);
      @(posedge clk);
      if (v) idx++;
      @(negedge clk);
    end
    ic_ld_valid = 1'b0;
    ic_ld_last  = 1'b0;
    check_eq("load_finished", {31'd0, finished}, 32'd1);
    check_eq("load_accepted", idx, exp_n);
    check_eq("load_nwrites", wlog.size(), exp_n);
    for (int i = 0; i < wlog.size() && i < 32; i++)
      check_eq("load_write", {1'b0, wlog[i]}, {1'b0, 5'(i), words[i]});
    check_eq("load_prog_len", {26'd0, ic_prog_len}, exp_n);
    check_eq("load_busy", {31'd0, ic_busy}, 32'd0);
    model_len = exp_n;
    for (int i = 0; i < exp_n; i++) prog[i] = words[i];
  endtask

  // mode 0: random ready, 1: ready held high, 2: 5-cycle stall on first issue
  task automatic run_prog(input int mode);
    logic [25:0] issued[$];
    logic [25:0] prev_iw;
    int  last_hs;
    int  stall_left;
    bit  prev_stall;
    bit  done_seen;
    bit  rdy;
    @(negedge clk);
    ic_run = 1'b1;
    @(negedge clk);
    ic_run = 1'b0;
    stall_left = 5;
    prev_stall = 1'b0;
    prev_iw    = '0;
    last_hs    = -1;
    done_seen  = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      case (mode)
        0: rdy = ($urandom_range(2) != 0);
        1: rdy = 1'b1;
        default: begin
          rdy = 1'b1;
          if (ic_iw_valid && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
          end
        end
      endcase
      ic_iw_ready = rdy;
      if (prev_stall) begin
        check_eq("iw_valid_hold", {31'd0, ic_iw_valid}, 32'd1);
        check_eq("iw_hold", {6'd0, ic_iw}, {6'd0, prev_iw});
      end
      if (ic_done) begin
        check_eq("done_no_valid", {31'd0, ic_iw_valid}, 32'd0);
        check_eq("done_count_issued", issued.size(), model_len);
        check_eq("done_timing", cyc, (model_len == 0) ? 0 : last_hs + 1);
        done_seen = 1'b1;
        @(negedge clk);
        check_eq("done_pulse_width", {31'd0, ic_done}, 32'd0);
        check_eq("idle_after_done", {31'd0, ic_busy}, 32'd0);
        break;
      end
      if (ic_iw_valid && rdy) begin
        if (mode == 1) check_eq("issue_timing", cyc, (last_hs < 0) ? 1 : last_hs + 2);
        issued.push_back(ic_iw);
        last_hs = cyc;
      end
      prev_stall = ic_iw_valid && !rdy;
      prev_iw    = ic_iw;
      @(negedge clk);
    end
    ic_iw_ready = 1'b0;
    check_eq("run_done_seen", {31'd0, done_seen}, 32'd1);
    check_eq("run_issue_count", issued.size(), model_len);
    for (int i = 0; i < issued.size() && i < model_len; i++)
      check_eq("run_iw", {6'd0, issued[i]}, {6'd0, prog[i]});
  endtask

  initial begin
    int n;
    int last;
    ic_rst_n      = 1'b0;
    ic_load_start = 1'b0;
    ic_ld_valid   = 1'b0;
    ic_ld_data    = '0;
    ic_ld_last    = 1'b0;
    ic_run        = 1'b0;
    ic_iw_ready   = 1'b0;
    model_len     = 0;
    for (int i = 0; i < 40; i++) words[i] = 26'($urandom);
    repeat (3) @(negedge clk);
    check_reset_state();
    #2 ic_rst_n = 1'b1;

    // Empty program after reset completes immediately
    run_prog(1);

    // Three-word program, load_start and run requested together
    words[0] = 26'h1;
    words[1] = 26'h2;
    words[2] = 26'h3;
    load_prog(3, 2, 1'b1);
    run_prog(1);

    // Overlong stream capped at 32 words, then a stalled run
    for (int i = 0; i < 40; i++) words[i] = 26'($urandom);
    load_prog(34, -1, 1'b0);
    run_prog(2);

    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < 40; i++) words[i] = 26'($urandom);
      n = int'($urandom_range(34, 1));
      last = ($urandom_range(1) == 1) ? int'($urandom_range(n - 1, 0)) : -1;
      if (last < 0 && n < 32) last = n - 1;
      load_prog(n, last, 1'b0);
      run_prog(0);
    end

    // Reset while the second load word is on the bus
    wlog.delete();
    @(negedge clk);
    ic_load_start = 1'b1;
    @(negedge clk);
    ic_load_start = 1'b0;
    ic_ld_valid   = 1'b1;
    ic_ld_data    = words[0];
    @(posedge clk);
    @(negedge clk);
    ic_ld_data = words[1];
    #2 ic_rst_n = 1'b0;
    #1 check_reset_state();
    check_eq("rst_first_write", wlog.size(), 1);
    @(posedge clk);
    #1 check_eq("rst_no_write", wlog.size(), 1);
    ic_ld_valid = 1'b0;
    #2 ic_rst_n = 1'b1;
    model_len = 0;
    run_prog(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
